// File: rtl/hex_display_ctrl.sv
// Register-mapped seven-segment controller: hex decode, per-digit blank/blink,
// leading-zero suppression and global enable, with a registered read port.
module hex_display_ctrl #(
   parameter int N_DIGITS   = 8,
   parameter int BLINK_HALF = 12_500_000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic [2:0]            wr_addr,
   input  logic [31:0]           wr_data,
   input  logic                  rd_en,
   input  logic [2:0]            rd_addr,
   output logic [31:0]           rd_data,
   output logic                  rd_valid,
   output logic [7*N_DIGITS-1:0] seg_o
);

   localparam int               CNT_W    = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLINK_HALF - 1);
   localparam logic [63:0]      NIB_MASK = (N_DIGITS >= 16) ? {64{1'b1}}
                                           : ((64'd1 << (4 * N_DIGITS)) - 64'd1);
   localparam logic [6:0]       SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;

   logic [31:0]          data0_q;
   logic [31:0]          data1_q;
   logic [N_DIGITS-1:0]  blank_q;
   logic [N_DIGITS-1:0]  blink_q;
   logic                 en_q;
   logic                 lzb_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 phase_q;
   logic [31:0]          rd_mux;
   logic [63:0]          nib_vec;
   logic [N_DIGITS-1:0]  lzsup;
   logic [7*N_DIGITS-1:0] seg_nxt;
   logic                 sync_wr;

   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      case (nib)
         4'h0: hex_decode = 7'h3F;
         4'h1: hex_decode = 7'h06;
         4'h2: hex_decode = 7'h5B;
         4'h3: hex_decode = 7'h4F;
         4'h4: hex_decode = 7'h66;
         4'h5: hex_decode = 7'h6D;
         4'h6: hex_decode = 7'h7D;
         4'h7: hex_decode = 7'h07;
         4'h8: hex_decode = 7'h7F;
         4'h9: hex_decode = 7'h6F;
         4'hA: hex_decode = 7'h77;
         4'hB: hex_decode = 7'h7C;
         4'hC: hex_decode = 7'h39;
         4'hD: hex_decode = 7'h5E;
         4'hE: hex_decode = 7'h79;
         default: hex_decode = 7'h71;
      endcase
   endfunction

   assign sync_wr = wr_en && (wr_addr == 3'd4) && wr_data[7];
   assign nib_vec = {data1_q, data0_q};

   always_comb begin
      rd_mux = '0;
      case (rd_addr)
         3'd0: rd_mux = data0_q;
         3'd1: rd_mux = data1_q;
         3'd2: rd_mux[N_DIGITS-1:0] = blank_q;
         3'd3: rd_mux[N_DIGITS-1:0] = blink_q;
         3'd4: rd_mux[1:0] = {lzb_q, en_q};
         default: rd_mux = '0;
      endcase
   end

   // Suppression runs from the top digit down and stops at the first nonzero nibble.
   always_comb begin
      logic run;
      run   = 1'b1;
      lzsup = '0;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         if (nib_vec[4*i +: 4] != 4'h0)
            run = 1'b0;
         lzsup[i] = run & lzb_q;
      end
   end

   always_comb begin
      logic lit;
      seg_nxt = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         lit = en_q & ~blank_q[i] & ~(blink_q[i] & phase_q) & ~lzsup[i];
         seg_nxt[7*i +: 7] = lit ? (hex_decode(nib_vec[4*i +: 4]) ^ SEG_OFF) : SEG_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data0_q  <= '0;
         data1_q  <= '0;
         blank_q  <= '0;
         blink_q  <= '0;
         en_q     <= 1'b0;
         lzb_q    <= 1'b0;
         cnt_q    <= '0;
         phase_q  <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         seg_o    <= {N_DIGITS{SEG_OFF}};
      end else begin
         if (wr_en) begin
            case (wr_addr)
               3'd0: data0_q <= wr_data & NIB_MASK[31:0];
               3'd1: data1_q <= wr_data & NIB_MASK[63:32];
               3'd2: blank_q <= wr_data[N_DIGITS-1:0];
               3'd3: blink_q <= wr_data[N_DIGITS-1:0];
               3'd4: begin
                  en_q  <= wr_data[0];
                  lzb_q <= wr_data[1];
               end
               default: ;
            endcase
         end
         if (sync_wr) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
         end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
         end else begin
            cnt_q   <= cnt_q + 1'b1;
         end
         rd_valid <= rd_en;
         if (rd_en)
            rd_data <= rd_mux;
         seg_o <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized and directed bench for hex_display_ctrl against a cycle-level
// behavioural model (N_DIGITS=8, BLINK_HALF=4, ACTIVE_LOW=1).
module tb_hex_display_ctrl;

   localparam int ND = 8;
   localparam int BH = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [2:0]    wr_addr = '0;
   logic [31:0]   wr_data = '0;
   logic          rd_en = 1'b0;
   logic [2:0]    rd_addr = '0;
   logic [31:0]   rd_data;
   logic          rd_valid;
   logic [7*ND-1:0] seg_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Model state
   logic [31:0] m_data0;
   logic [7:0]  m_blank, m_blink;
   logic        m_en, m_lzb;
   int          m_tick;
   logic [31:0] m_rd_data;
   logic        m_rd_valid;
   logic [55:0] m_seg;

   hex_display_ctrl #(.N_DIGITS(ND), .BLINK_HALF(BH), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .seg_o(seg_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic model_phase();
      return ((m_tick / BH) % 2) == 1;
   endfunction

   function automatic logic [3:0] nib(input int d);
      return 4'((m_data0 >> (4 * d)) & 32'hF);
   endfunction

   function automatic logic [55:0] model_seg();
      logic [55:0] s;
      int hi;
      logic lit;
      hi = 0;
      for (int d = 0; d < ND; d++)
         if (nib(d) != 4'h0) hi = d;
      s = '1;
      for (int d = 0; d < ND; d++) begin
         lit = m_en && !m_blank[d] && !(m_blink[d] && model_phase()) && !(m_lzb && d > hi);
         if (lit) s[7*d +: 7] = ~font[nib(d)];
      end
      return s;
   endfunction

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0: return m_data0;
         3'd2: return {24'h0, m_blank};
         3'd3: return {24'h0, m_blink};
         3'd4: return {30'h0, m_lzb, m_en};
         default: return 32'h0;
      endcase
   endfunction

   // One clock: drive at negedge, advance model at posedge, compare 1 time unit later.
   task automatic step(input logic rn, input logic we, input logic [2:0] wa,
                       input logic [31:0] wd, input logic re, input logic [2:0] ra);
      logic sync;
      @(negedge clk);
      reset_n = rn; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
      @(posedge clk);
      if (!rn) begin
         m_seg = '1;
         m_data0 = '0; m_blank = '0; m_blink = '0; m_en = 0; m_lzb = 0;
         m_tick = 0; m_rd_data = '0; m_rd_valid = 0;
      end else begin
         m_seg = model_seg();
         m_rd_valid = re;
         if (re) m_rd_data = model_read(ra);
         sync = 0;
         if (we) begin
            case (wa)
               3'd0: m_data0 = wd;
               3'd2: m_blank = wd[7:0];
               3'd3: m_blink = wd[7:0];
               3'd4: begin m_en = wd[0]; m_lzb = wd[1]; sync = wd[7]; end
               default: ;
            endcase
         end
         m_tick = sync ? 0 : m_tick + 1;
      end
      #1;
      chk("seg_o", 64'(seg_o), 64'(m_seg));
      chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
      chk("rd_data", 64'(rd_data), 64'(m_rd_data));
   endtask

   task automatic idle();
      step(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int guard;
      // Reset
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 3'd4, 32'h1, 1, 3'd0);
      chk("rst_seg", 64'(seg_o), 64'({56{1'b1}}));
      step(1, 0, 0, 0, 1, 3'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd1);
      chk("rst_rd_data", 64'(rd_data), 64'd0);

      // Decode
      step(1, 1, 3'd4, 32'h1, 0, 0);
      step(1, 1, 3'd0, 32'h0123_4567, 0, 0);
      idle();
      chk("dec_d0", 64'(seg_o[6:0]), 64'h78);
      chk("dec_d7", 64'(seg_o[55:49]), 64'h40);
      chk("dec_d3", 64'(seg_o[27:21]), 64'h19);

      // Leading-zero blanking
      step(1, 1, 3'd4, 32'h3, 0, 0);
      step(1, 1, 3'd0, 32'h0000_00A0, 0, 0);
      idle();
      chk("lzb_hi", 64'(seg_o[55:14]), 64'({6{7'h7F}}));
      chk("lzb_d1", 64'(seg_o[13:7]), 64'h08);
      chk("lzb_d0", 64'(seg_o[6:0]), 64'h40);
      step(1, 1, 3'd0, 32'h0, 0, 0);
      idle();
      chk("lzb_zero", 64'(seg_o), 64'({{7{7'h7F}}, 7'h40}));

      // Blink with sync: digit0 visible 4 cycles, dark 4 cycles
      step(1, 1, 3'd3, 32'h1, 0, 0);
      step(1, 1, 3'd4, 32'h81, 0, 0);
      for (int c = 0; c < 16; c++) begin
         idle();
         chk("blink_d0", 64'(seg_o[6:0]), ((c % 8) < 4) ? 64'h40 : 64'h7F);
         chk("blink_rest", 64'(seg_o[55:7]), 64'({7{7'h40}}));
      end
      step(1, 0, 0, 0, 1, 3'd4);
      chk("ctrl_rdback", 64'(rd_data), 64'd1);

      // Bus corners
      step(1, 1, 3'd0, 32'h5, 0, 0);
      step(1, 1, 3'd0, 32'h9, 1, 3'd0);
      chk("rw_old", 64'(rd_data), 64'd5);
      step(1, 0, 0, 0, 1, 3'd0);
      chk("rw_new", 64'(rd_data), 64'd9);
      step(1, 1, 3'd6, 32'hFFFF_FFFF, 0, 0);
      step(1, 1, 3'd1, 32'hFFFF_FFFF, 1, 3'd6);
      chk("rsv_rd", 64'(rd_data), 64'd0);
      step(1, 0, 0, 0, 1, 3'd1);
      chk("data1_rd", 64'(rd_data), 64'd0);

      // Reset while the blink phase is hidden
      guard = 0;
      while (!model_phase() && guard < 20) begin idle(); guard++; end
      chk("phase_wait", 64'(model_phase()), 64'd1);
      step(0, 1, 3'd0, 32'h1234, 1, 3'd0);
      chk("midrst_seg", 64'(seg_o), 64'({56{1'b1}}));
      for (int a = 0; a < 8; a++) begin
         step(1, 0, 0, 0, 1, 3'(a));
         chk("midrst_reg", 64'(rd_data), 64'd0);
      end

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic [31:0] wd;
         logic [2:0]  wa;
         wa = 3'($urandom_range(0, 7));
         wd = $urandom;
         if (wa == 3'd4) wd = {24'h0, ($urandom_range(0, 7) == 0), 5'h0, 2'($urandom_range(0, 3) | 1)};
         if (wa == 3'd0 && $urandom_range(0, 2) == 0) wd = wd >> (4 * $urandom_range(1, 7));
         step(($urandom_range(0, 60) != 0), ($urandom_range(0, 2) == 0), wa, wd,
              ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
